// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ZERO,
      LOAD,
      DONE,
      ERROR
   } state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned ADDR_W_DEF = 8;
   localparam logic [1:0]  LAST_IDX   = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; a flush on a partial word
// emits it with the missing low bytes zero-padded.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        accept_i,
   input  logic [7:0]  data_i,
   input  logic        last_i,
   output logic [1:0]  idx_o,
   output logic        word_ready_o,
   output logic [31:0] word_o
);

   logic [1:0]  idx_q;
   logic [23:0] sh_q;
   logic [31:0] padded;

   always_comb begin
      padded = '0;
      case (idx_q)
         2'd0:    padded = {data_i, 24'h0};
         2'd1:    padded = {sh_q[7:0], data_i, 16'h0};
         2'd2:    padded = {sh_q[15:0], data_i, 8'h0};
         default: padded = {sh_q[23:0], data_i};
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q        <= '0;
         sh_q         <= '0;
         word_ready_o <= 1'b0;
         word_o       <= '0;
      end else if (accept_i) begin
         if (idx_q == LAST_IDX || last_i) begin
            word_o       <= padded;
            word_ready_o <= 1'b1;
            sh_q         <= '0;
            idx_q        <= '0;
         end else begin
            sh_q         <= {sh_q[15:0], data_i};
            idx_q        <= idx_q + 2'd1;
            word_ready_o <= 1'b0;
         end
      end else begin
         word_ready_o <= 1'b0;
      end
   end

   assign idx_o = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: zero-fills instruction memory, then streams a byte image into
// consecutive words and raises start_o once the last word has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   input  logic              byte_last_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              start_o,
   output logic              busy_o,
   output logic              error_o,
   output logic [ADDR_W:0]   word_count_o
);

   localparam logic [ADDR_W:0] DEPTH    = (ADDR_W + 1)'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W + 1)'(2 ** ADDR_W - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              zwe_q, zwe_d;
   logic              fin_q, fin_d;
   logic              ferr_q, ferr_d;
   logic              start_q, start_d;
   logic              accept, full, pack_accept;
   logic [1:0]        pack_idx;
   logic              pack_ready;
   logic [31:0]       pack_word;

   assign byte_ready_o = (state_q == LOAD) && !fin_q;
   assign accept       = byte_valid_i && byte_ready_o;
   // A write still in flight counts toward the limit, so a byte arriving
   // right behind the last possible word is caught as overflow.
   assign full         = (count_q == DEPTH) || (pack_ready && count_q == DEPTH_M1);
   assign pack_accept  = accept && !full;

   byte_packer u_packer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .accept_i     (pack_accept),
      .data_i       (byte_data_i),
      .last_i       (byte_last_i),
      .idx_o        (pack_idx),
      .word_ready_o (pack_ready),
      .word_o       (pack_word)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         count_q <= '0;
         zwe_q   <= 1'b0;
         fin_q   <= 1'b0;
         ferr_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         zwe_q   <= zwe_d;
         fin_q   <= fin_d;
         ferr_q  <= ferr_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      zwe_d   = 1'b0;
      fin_d   = fin_q;
      ferr_d  = ferr_q;
      start_d = start_q;
      case (state_q)
         IDLE: begin
            state_d = ZERO;
            addr_d  = '0;
            zwe_d   = 1'b1;
         end
         ZERO: begin
            if (addr_q == '1) begin
               state_d = LOAD;
               addr_d  = '0;
               count_d = '0;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               zwe_d  = 1'b1;
            end
         end
         LOAD: begin
            if (pack_ready) begin
               addr_d  = addr_q + ADDR_W'(1);
               count_d = count_q + (ADDR_W + 1)'(1);
            end
            // Termination is decided when the byte is taken but applied one
            // edge later, after the final write has been presented.
            if (fin_q) begin
               state_d = ferr_q ? ERROR : DONE;
            end else if (accept) begin
               if (full) begin
                  fin_d  = 1'b1;
                  ferr_d = 1'b1;
               end else if (byte_last_i) begin
                  fin_d  = 1'b1;
                  ferr_d = (pack_idx != LAST_IDX);
               end
            end
         end
         DONE:    start_d = 1'b1;
         default: ;
      endcase
   end

   assign imem_we_o    = zwe_q || pack_ready;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = pack_ready ? pack_word : '0;
   assign start_o      = start_q;
   assign busy_o       = (state_q == ZERO) || (state_q == LOAD);
   assign error_o      = (state_q == ERROR);
   assign word_count_o = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected memory writes into
// a scoreboard queue that an independent monitor drains on every write strobe.
module tb_imem_loader;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_last = 1'b0;
   logic        byte_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        start;
   logic        busy;
   logic        error;
   logic [8:0]  word_count;

   int total = 0;
   int bad   = 0;
   wr_t exp_q[$];

   imem_loader #(.ADDR_W(8)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .byte_valid_i (byte_valid),
      .byte_data_i  (byte_data),
      .byte_last_i  (byte_last),
      .byte_ready_o (byte_ready),
      .imem_we_o    (imem_we),
      .imem_addr_o  (imem_addr),
      .imem_wdata_o (imem_wdata),
      .start_o      (start),
      .busy_o       (busy),
      .error_o      (error),
      .word_count_o (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      wr_t e;
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                     imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(imem_addr), 64'(e.a));
            chk("wr_data", 64'(imem_wdata), 64'(e.d));
         end
      end
   end

   task automatic push_wr(input int a, input logic [31:0] d);
      wr_t e;
      e.a = 8'(a);
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1;
      byte_valid = 1'b0;
      #1;
      chk("rst_we",    64'(imem_we), 64'(0));
      chk("rst_addr",  64'(imem_addr), 64'(0));
      chk("rst_wdata", 64'(imem_wdata), 64'(0));
      chk("rst_start", 64'(start), 64'(0));
      chk("rst_busy",  64'(busy), 64'(0));
      chk("rst_error", 64'(error), 64'(0));
      chk("rst_ready", 64'(byte_ready), 64'(0));
      chk("rst_count", 64'(word_count), 64'(0));
      chk("rst_queue_empty", 64'(exp_q.size()), 64'(0));
      repeat (2) @(posedge clk);
      for (int i = 0; i < 256; i++) push_wr(i, 32'h0);
      #1 rst = 1'b0;
      n = 0;
      while (!byte_ready && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("zero_fill_ready", 64'(byte_ready), 64'(1));
      chk("zero_fill_cycles", 64'(n), 64'(257));
      chk("zero_writes_drained", 64'(exp_q.size()), 64'(0));
      chk("load_busy",  64'(busy), 64'(1));
      chk("load_start", 64'(start), 64'(0));
      chk("load_error", 64'(error), 64'(0));
      chk("load_count", 64'(word_count), 64'(0));
   endtask

   task automatic send(input logic [7:0] d, input logic l, input bit rnd);
      int n;
      if (rnd) begin
         n = $urandom_range(0, 2);
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         byte_last  = 1'b1;
         repeat (n) begin
            @(posedge clk);
            #1;
         end
      end
      byte_valid = 1'b1;
      byte_data  = d;
      byte_last  = l;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!byte_ready) begin
         chk("byte_accept_timeout", 64'(byte_ready), 64'(1));
      end else begin
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic send_image(input bit rnd);
      logic [7:0] img [8];
      img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
      push_wr(0, 32'h20080005);
      push_wr(1, 32'h2009000A);
      for (int i = 0; i < 8; i++) send(img[i], (i == 7), rnd);
   endtask

   initial begin
      int n;
      #2;
      do_reset();

      // Back-to-back image, check start timing.
      send_image(1'b0);
      chk("done_start_t0", 64'(start), 64'(0));
      chk("done_ready_low", 64'(byte_ready), 64'(0));
      @(posedge clk); #1;
      chk("done_start_t1", 64'(start), 64'(0));
      chk("done_busy_t1",  64'(busy), 64'(0));
      chk("done_count",    64'(word_count), 64'(2));
      @(posedge clk); #1;
      chk("done_start_t2", 64'(start), 64'(1));
      chk("done_error",    64'(error), 64'(0));
      chk("done_queue",    64'(exp_q.size()), 64'(0));

      // Same image with gaps and junk on the bus while invalid.
      do_reset();
      send_image(1'b1);
      n = 0;
      while (!start && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("gap_start_cycles", 64'(n), 64'(2));
      chk("gap_count", 64'(word_count), 64'(2));
      chk("gap_error", 64'(error), 64'(0));
      chk("gap_queue", 64'(exp_q.size()), 64'(0));

      // Partial last word.
      do_reset();
      push_wr(0, 32'h20080005);
      push_wr(1, 32'hAABB0000);
      send(8'h20, 1'b0, 1'b0);
      send(8'h08, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'h05, 1'b0, 1'b0);
      send(8'hAA, 1'b0, 1'b0);
      send(8'hBB, 1'b1, 1'b0);
      chk("part_error_t0", 64'(error), 64'(0));
      @(posedge clk); #1;
      chk("part_error", 64'(error), 64'(1));
      chk("part_count", 64'(word_count), 64'(2));
      chk("part_busy",  64'(busy), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("part_start", 64'(start), 64'(0));
      chk("part_queue", 64'(exp_q.size()), 64'(0));

      // Overflow: 256 full words, then one byte too many.
      do_reset();
      for (int i = 0; i < 256; i++)
         push_wr(i, {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
      for (int k = 0; k < 1024; k++) send(8'(k), 1'b0, 1'b0);
      send(8'hEE, 1'b0, 1'b0);
      chk("ovf_ready_low", 64'(byte_ready), 64'(0));
      chk("ovf_error_t0",  64'(error), 64'(0));
      @(posedge clk); #1;
      chk("ovf_error", 64'(error), 64'(1));
      chk("ovf_count", 64'(word_count), 64'(256));
      chk("ovf_start", 64'(start), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      chk("ovf_queue", 64'(exp_q.size()), 64'(0));

      // Reset in the middle of a load.
      do_reset();
      push_wr(0, 32'h11223344);
      push_wr(1, 32'h55667788);
      send(8'h11, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      send(8'h33, 1'b0, 1'b0);
      send(8'h44, 1'b0, 1'b0);
      send(8'h55, 1'b0, 1'b0);
      send(8'h66, 1'b0, 1'b0);
      send(8'h77, 1'b0, 1'b0);
      send(8'h88, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_count", 64'(word_count), 64'(2));
      chk("mid_busy",  64'(busy), 64'(1));
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
